// File: rtl/interval_capture_if.sv
// Bundle of the arm/event inputs and measurement outputs of interval_capture.
// Also carries the encoded FSM state for observation.
interface interval_capture_if #(
  parameter int W = 8
);
  // Protocol: start is a single-cycle arm pulse sampled on the rising clock.
  // mark is a synchronous level; only its 0->1 transitions matter.
  // value/valid/busy/over are registered levels. valid=1 means value holds a
  // completed interval, and no acknowledge is needed.
  logic         start;
  logic         mark;
  logic [W-1:0] value;
  logic         valid;
  logic         busy;
  logic         over;
  logic [1:0]   dbg_state;

  modport master (
    output start, mark,
    input  value, valid, busy, over, dbg_state
  );

  modport slave (
    input  start, mark,
    output value, valid, busy, over, dbg_state
  );
endinterface

// File: rtl/interval_capture.sv
// Measures clock cycles between two rising edges of mark after a start pulse.
// Optional INTERVAL_CAPTURE_REARM_EN: terminating edge also starts the next period.
module interval_capture #(
  parameter int W = 8
) (
  input  logic               clock,
  input  logic               reset,
  interval_capture_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  state_t       r_state, w_state_nxt;
  logic         r_mark_q;
  logic [W-1:0] r_count, w_count_nxt;
  logic [W-1:0] r_value, w_value_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_over,  w_over_nxt;
  logic         r_busy;
  logic         w_edge;
  logic         w_busy_nxt;
`ifdef INTERVAL_CAPTURE_REARM_EN
  // Saturation seen in the interval currently being counted.
  logic         r_sat, w_sat_nxt;
`endif

  assign w_edge     = bus.mark & ~r_mark_q;
  assign w_busy_nxt = (w_state_nxt == S_WAIT) || (w_state_nxt == S_COUNT);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_value_nxt = r_value;
    w_valid_nxt = r_valid;
    w_over_nxt  = r_over;
`ifdef INTERVAL_CAPTURE_REARM_EN
    w_sat_nxt   = r_sat;
`endif
    // start has priority in every state, including over a coincident edge.
    if (bus.start) begin
      w_state_nxt = S_WAIT;
      w_count_nxt = '0;
      w_value_nxt = '0;
      w_valid_nxt = 1'b0;
      w_over_nxt  = 1'b0;
`ifdef INTERVAL_CAPTURE_REARM_EN
      w_sat_nxt   = 1'b0;
`endif
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_edge) begin
            w_state_nxt = S_COUNT;
            w_count_nxt = ONE;
          end
        end
        S_COUNT: begin
          if (w_edge) begin
            w_value_nxt = r_count;
            w_valid_nxt = 1'b1;
`ifdef INTERVAL_CAPTURE_REARM_EN
            w_count_nxt = ONE;
            w_over_nxt  = r_sat;
            w_sat_nxt   = 1'b0;
`else
            w_state_nxt = S_DONE;
`endif
          end else if (r_count != MAX) begin
            w_count_nxt = r_count + ONE;
          end else begin
`ifdef INTERVAL_CAPTURE_REARM_EN
            w_sat_nxt   = 1'b1;
`else
            w_over_nxt  = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mark_q <= 1'b0;
      r_count  <= '0;
      r_value  <= '0;
      r_valid  <= 1'b0;
      r_over   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef INTERVAL_CAPTURE_REARM_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_mark_q <= bus.mark;
      r_count  <= w_count_nxt;
      r_value  <= w_value_nxt;
      r_valid  <= w_valid_nxt;
      r_over   <= w_over_nxt;
      r_busy   <= w_busy_nxt;
`ifdef INTERVAL_CAPTURE_REARM_EN
      r_sat    <= w_sat_nxt;
`endif
    end
  end

  assign bus.value     = r_value;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.over      = r_over;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_interval_capture.sv
// Directed bench for interval_capture; expected values are hand-derived from
// the edge-to-edge cycle counts driven below.
module tb_interval_capture;
  localparam int W = 8;
`ifdef INTERVAL_CAPTURE_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif
  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_WAIT  = 32'd1;
  localparam logic [31:0] ST_COUNT = 32'd2;
  localparam logic [31:0] ST_DONE  = 32'd3;

  logic clock = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  interval_capture_if #(.W(W)) bus ();

  interval_capture #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // First rising edge, then a second one exactly n cycles later (n >= 2).
  task automatic measure(input int n);
    bus.mark = 1'b1;
    step();
    bus.mark = 1'b0;
    steps(n - 1);
    chk("busy_before_capture", bus.busy, 32'd1);
    chk("valid_before_capture", bus.valid, 32'd0);
    bus.mark = 1'b1;
    step();
    bus.mark = 1'b0;
  endtask

  task automatic pulse();
    bus.mark = 1'b1;
    step();
    bus.mark = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mark  = 1'b0;
    steps(3);
    reset = 1'b0;
    chk("rst_value", bus.value, 32'd0);
    chk("rst_valid", bus.valid, 32'd0);
    chk("rst_busy",  bus.busy,  32'd0);
    chk("rst_over",  bus.over,  32'd0);
    chk("rst_state", bus.dbg_state, ST_IDLE);

    // Basic 25-cycle interval
    step();
    arm();
    chk("arm_busy",  bus.busy, 32'd1);
    chk("arm_state", bus.dbg_state, ST_WAIT);
    steps(4);
    measure(25);
    chk("t25_value", bus.value, 32'd25);
    chk("t25_valid", bus.valid, 32'd1);
    chk("t25_over",  bus.over,  32'd0);
    chk("t25_busy",  bus.busy,  REARM ? 32'd1 : 32'd0);
    chk("t25_state", bus.dbg_state, REARM ? ST_COUNT : ST_DONE);
    steps(3);
    chk("t25_hold_value", bus.value, 32'd25);
    chk("t25_hold_valid", bus.valid, 32'd1);

    // Shortest possible interval on a single line: 0,1,0,1
    arm();
    chk("arm_clears_valid", bus.valid, 32'd0);
    chk("arm_clears_value", bus.value, 32'd0);
    measure(2);
    chk("min_value", bus.value, 32'd2);
    chk("min_valid", bus.valid, 32'd1);

    // Saturation: 300 cycles overflows, 255 exactly does not
    arm();
    measure(300);
    chk("sat300_value", bus.value, 32'd255);
    chk("sat300_over",  bus.over,  32'd1);
    arm();
    chk("arm_clears_over", bus.over, 32'd0);
    measure(255);
    chk("max255_value", bus.value, 32'd255);
    chk("max255_over",  bus.over,  32'd0);
    chk("max255_valid", bus.valid, 32'd1);

    // Restart during COUNT
    arm();
    pulse();
    steps(4);
    chk("pre_restart_state", bus.dbg_state, ST_COUNT);
    arm();
    chk("restart_valid", bus.valid, 32'd0);
    chk("restart_busy",  bus.busy,  32'd1);
    chk("restart_state", bus.dbg_state, ST_WAIT);
    measure(7);
    chk("restart_value", bus.value, 32'd7);

    // start coincident with an edge: start wins, edge ignored
    bus.start = 1'b1;
    bus.mark  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mark  = 1'b0;
    chk("coinc_state", bus.dbg_state, ST_WAIT);
    chk("coinc_valid", bus.valid, 32'd0);
    chk("coinc_busy",  bus.busy,  32'd1);
    steps(2);
    chk("coinc_still_wait", bus.dbg_state, ST_WAIT);
    measure(4);
    chk("coinc_value", bus.value, 32'd4);

    // Reset with a completed result present
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_done_value", bus.value, 32'd0);
    chk("rst_done_valid", bus.valid, 32'd0);
    chk("rst_done_state", bus.dbg_state, ST_IDLE);

    // Reset mid-COUNT aborts
    arm();
    pulse();
    steps(10);
    chk("mid_state", bus.dbg_state, ST_COUNT);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_value", bus.value, 32'd0);
    chk("midrst_valid", bus.valid, 32'd0);
    chk("midrst_busy",  bus.busy,  32'd0);
    chk("midrst_over",  bus.over,  32'd0);
    chk("midrst_state", bus.dbg_state, ST_IDLE);

    // mark high across reset release: edge seen in IDLE is ignored
    bus.mark = 1'b1;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("relmark_state", bus.dbg_state, ST_IDLE);
    chk("relmark_busy",  bus.busy, 32'd0);
    bus.mark = 1'b0;
    step();

    // Level-held mark produces only one edge
    arm();
    bus.mark = 1'b1;
    step();
    steps(10);
    chk("level_state", bus.dbg_state, ST_COUNT);
    chk("level_valid", bus.valid, 32'd0);
    bus.mark = 1'b0;
    step();
    pulse();
    chk("level_value", bus.value, 32'd12);

`ifdef INTERVAL_CAPTURE_REARM_EN
    // Back-to-back periods: edges 10 then 25 cycles apart
    arm();
    steps(4);
    pulse();
    steps(9);
    pulse();
    chk("rearm1_value", bus.value, 32'd10);
    chk("rearm1_valid", bus.valid, 32'd1);
    chk("rearm1_busy",  bus.busy,  32'd1);
    chk("rearm1_state", bus.dbg_state, ST_COUNT);
    steps(24);
    pulse();
    chk("rearm2_value", bus.value, 32'd35 - 32'd10);
    chk("rearm2_valid", bus.valid, 32'd1);
    chk("rearm2_busy",  bus.busy,  32'd1);
`else
    // DONE ignores further edges until the next start
    arm();
    measure(6);
    pulse();
    steps(5);
    pulse();
    chk("done_hold_value", bus.value, 32'd6);
    chk("done_hold_state", bus.dbg_state, ST_DONE);
    chk("done_hold_busy",  bus.busy, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
